alu_main: RTL and testbench



---
 rtl/alu_main.sv | 128 ++++++++++++
 tb/tb_alu_main.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_main.sv
// alu_main: clocked 8-bit ALU with per-operand input muxes, one-hot
// operation select, registered result and a 2-bit sequence FSM.
// Ports:
//   clk, rst        - rising-edge clock, async active-high reset
//   on              - enable; 0 forces the FSM to OFF
//   in_sel[2:0]     - operand mux: [0] clear, [1] load, [2] persist (= hold)
//   num1, num2      - operand A / B inputs
//   final1, final2  - operand A / B registers
//   out_sel[6:0]    - one-hot op select (ADD,SUB,MUL,DIV,AND,OR,XOR from bit6)
//   out             - registered ALU result
//   currState       - state register; nextState - combinational next state
module alu_main (
  input  logic       clk,
  input  logic       rst,
  input  logic       on,
  input  logic [2:0] in_sel,
  input  logic [7:0] num1,
  input  logic [7:0] num2,
  output logic [7:0] final1,
  output logic [7:0] final2,
  input  logic [6:0] out_sel,
  output logic [7:0] out,
  output logic [1:0] currState,
  output logic [1:0] nextState
);

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 7;

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_READY = 2'b01,
    S_EXEC  = 2'b10,
    S_ERROR = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DW-1:0]     r_a;
  logic [DW-1:0]     r_b;
  logic [DW-1:0]     r_out;
  logic              w_sel_valid;
  logic [2*DW-1:0]   w_mul;
  logic [DW-1:0]     w_alu;

  // Exactly one select bit set.
  assign w_sel_valid = (out_sel != SW'(0)) && ((out_sel & (out_sel - SW'(1))) == SW'(0));

  // Next-state logic; enable has top priority.
  always_comb begin
    w_next = r_state;
    if (!on) begin
      w_next = S_OFF;
    end else begin
      case (r_state)
        S_OFF:   w_next = S_READY;
        S_READY: w_next = w_sel_valid ? S_EXEC  : S_ERROR;
        S_EXEC:  w_next = w_sel_valid ? S_EXEC  : S_ERROR;
        S_ERROR: w_next = w_sel_valid ? S_READY : S_ERROR;
        default: w_next = S_OFF;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_OFF;
    else     r_state <= w_next;
  end

  // Combinational ALU on the operand registers; invalid select yields 0.
  assign w_mul = (2*DW)'(r_a) * (2*DW)'(r_b);

  always_comb begin
    w_alu = '0;
    case (out_sel)
      7'b1000000: w_alu = r_a + r_b;
      7'b0100000: w_alu = r_a - r_b;
      7'b0010000: w_alu = w_mul[DW-1:0];
      7'b0001000: w_alu = (r_b == DW'(0)) ? DW'(8'hFF) : (r_a / r_b);
      7'b0000100: w_alu = r_a & r_b;
      7'b0000010: w_alu = r_a | r_b;
      7'b0000001: w_alu = r_a ^ r_b;
      default:    w_alu = '0;
    endcase
  end

  // Operand registers: clear beats load; persist behaves as hold; frozen in OFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (r_state != S_OFF) begin
      casez (in_sel)
        3'b??1: begin
          r_a <= '0;
          r_b <= '0;
        end
        3'b?10: begin
          r_a <= num1;
          r_b <= num2;
        end
        default: begin
          r_a <= r_a;
          r_b <= r_b;
        end
      endcase
    end
  end

  // Result register: cleared when powering off or in OFF, loaded only from EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else if (!on || (r_state == S_OFF)) begin
      r_out <= '0;
    end else if (r_state == S_EXEC) begin
      r_out <= w_alu;
    end
  end

  assign final1    = r_a;
  assign final2    = r_b;
  assign out       = r_out;
  assign currState = r_state;
  assign nextState = w_next;

endmodule

// File: tb/tb_alu_main.sv
module tb_alu_main;

  logic       clk;
  logic       rst;
  logic       on;
  logic [2:0] in_sel;
  logic [7:0] num1;
  logic [7:0] num2;
  logic [7:0] final1;
  logic [7:0] final2;
  logic [6:0] out_sel;
  logic [7:0] out;
  logic [1:0] currState;
  logic [1:0] nextState;

  alu_main dut (
    .clk(clk), .rst(rst), .on(on), .in_sel(in_sel),
    .num1(num1), .num2(num2), .final1(final1), .final2(final2),
    .out_sel(out_sel), .out(out), .currState(currState), .nextState(nextState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int nx;
    int a;
    int b;
    int o;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (integers, spec-level rules)
  int m_state, m_a, m_b, m_out;
  int p_on, p_insel, p_n1, p_n2, p_sel;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ones(input int v);
    int c = 0;
    for (int i = 0; i < 7; i++) c += (v >> i) & 1;
    return c;
  endfunction

  function automatic int ref_alu(input int a, input int b, input int sel);
    if (ones(sel) != 1) return 0;
    if (sel == 64) return (a + b) % 256;
    if (sel == 32) return (a - b + 256) % 256;
    if (sel == 16) return (a * b) % 256;
    if (sel == 8)  return (b == 0) ? 255 : a / b;
    if (sel == 4)  return a & b;
    if (sel == 2)  return a | b;
    return a ^ b;
  endfunction

  function automatic int ref_next(input int st, input int en, input int sel);
    bit v = (ones(sel) == 1);
    if (en == 0) return 0;
    if (st == 0) return 1;
    if (st == 1) return v ? 2 : 3;
    if (st == 2) return v ? 2 : 3;
    return v ? 1 : 3;
  endfunction

  // Apply one clock edge of the model using the inputs held before that edge.
  task automatic model_edge();
    int ns, na, nb, no;
    ns = ref_next(m_state, p_on, p_sel);
    na = m_a; nb = m_b;
    if (m_state != 0) begin
      if (p_insel % 2 == 1)              begin na = 0;    nb = 0;    end
      else if ((p_insel / 2) % 2 == 1)   begin na = p_n1; nb = p_n2; end
    end
    no = m_out;
    if (p_on == 0 || m_state == 0) no = 0;
    else if (m_state == 2)          no = ref_alu(m_a, m_b, p_sel);
    m_state = ns; m_a = na; m_b = nb; m_out = no;
  endtask

  task automatic apply_push(input int en, input int ins, input int a, input int b, input int sel);
    exp_t e;
    on = 1'(en); in_sel = 3'(ins); num1 = 8'(a); num2 = 8'(b); out_sel = 7'(sel);
    p_on = en; p_insel = ins; p_n1 = a; p_n2 = b; p_sel = sel;
    e.st = m_state; e.a = m_a; e.b = m_b; e.o = m_out;
    e.nx = ref_next(m_state, en, sel);
    q.push_back(e);
  endtask

  // One cycle: edge happens, model follows it, new inputs driven, expectation queued.
  task automatic cycle(input int en, input int ins, input int a, input int b, input int sel);
    @(posedge clk); #1;
    model_edge();
    apply_push(en, ins, a, b, sel);
  endtask

  task automatic release_reset(input int en, input int ins, input int a, input int b, input int sel);
    @(posedge clk); #1;
    rst = 1'b0;
    m_state = 0; m_a = 0; m_b = 0; m_out = 0;
    apply_push(en, ins, a, b, sel);
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 10) begin
      @(negedge clk); #1;
      k++;
    end
    check("queue_drain", q.size(), 0);
  endtask

  // Monitor: compare every queued expectation mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      check("currState", int'(currState), e.st);
      check("nextState", int'(nextState), e.nx);
      check("final1",    int'(final1),    e.a);
      check("final2",    int'(final2),    e.b);
      check("out",       int'(out),       e.o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  localparam int ADD = 64, SUB = 32, MUL = 16, DIV = 8, AND_ = 4, OR_ = 2, XOR_ = 1;
  localparam int LD = 2, CLR = 1, HOLD = 0;

  initial begin
    int sel;
    rst = 1'b1; on = 1'b1; in_sel = 3'b010; num1 = 8'h57; num2 = 8'h1A; out_sel = 7'b1000000;
    repeat (2) @(posedge clk);
    check("rst_out", int'(out), 0);
    check("rst_state", int'(currState), 0);

    // Load / ADD
    release_reset(1, LD, 8'h57, 8'h1A, ADD);
    cycle(1, LD, 8'h57, 8'h1A, ADD);
    cycle(1, HOLD, 8'h57, 8'h1A, ADD);
    cycle(1, HOLD, 8'h57, 8'h1A, ADD);
    cycle(1, LD, 8'h02, 8'h04, ADD);
    cycle(1, HOLD, 0, 0, ADD);
    cycle(1, HOLD, 0, 0, ADD);
    // Operation sweep on 0x57/0x1A
    cycle(1, LD, 8'h57, 8'h1A, SUB);
    cycle(1, HOLD, 0, 0, SUB);
    cycle(1, HOLD, 0, 0, MUL);
    cycle(1, HOLD, 0, 0, DIV);
    cycle(1, HOLD, 0, 0, AND_);
    cycle(1, HOLD, 0, 0, OR_);
    cycle(1, 4, 0, 0, XOR_);
    cycle(1, HOLD, 0, 0, XOR_);
    // Divide by zero, then clear
    cycle(1, LD, 8'h40, 8'h00, DIV);
    cycle(1, HOLD, 0, 0, DIV);
    cycle(1, HOLD, 0, 0, DIV);
    cycle(1, CLR, 8'h11, 8'h22, DIV);
    cycle(1, 3, 8'h11, 8'h22, ADD);
    // Invalid select, then recover
    cycle(1, LD, 8'h0F, 8'h03, 7'b0000011);
    cycle(1, HOLD, 0, 0, 7'b0000011);
    cycle(1, HOLD, 0, 0, MUL);
    cycle(1, HOLD, 0, 0, MUL);
    cycle(1, HOLD, 0, 0, MUL);
    // Power off and back on
    cycle(0, HOLD, 0, 0, MUL);
    cycle(0, LD, 8'hAA, 8'hBB, MUL);
    cycle(1, HOLD, 0, 0, MUL);
    cycle(1, HOLD, 0, 0, MUL);
    cycle(1, HOLD, 0, 0, MUL);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) != 0) sel = 1 << $urandom_range(0, 6);
      else                           sel = int'($urandom_range(0, 127));
      cycle(($urandom_range(0, 15) != 0) ? 1 : 0, int'($urandom_range(0, 7)),
            int'($urandom_range(0, 255)),
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)), sel);
    end
    drain();

    // Asynchronous reset mid-cycle, checked before the next edge
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_final1", int'(final1), 0);
    check("async_final2", int'(final2), 0);
    check("async_out", int'(out), 0);
    check("async_state", int'(currState), 0);
    release_reset(1, LD, 8'h09, 8'h03, DIV);
    for (int i = 0; i < 6; i++) cycle(1, HOLD, 0, 0, DIV);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
